// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction controller: FSM states,
// ISA opcode/op values, ALU operation codes and register-index selection.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef enum logic [1:0] {
        NSEL_RN,
        NSEL_RD,
        NSEL_RM
    } nsel_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } ir_fields_t;

    function automatic logic [2:0] select_reg(input nsel_t nsel, input ir_fields_t f);
        case (nsel)
            NSEL_RD: select_reg = f.rd;
            NSEL_RM: select_reg = f.rm;
            default: select_reg = f.rn;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Splits the instruction register into its fields and sign-extends imm8
// for the datapath write-back input.
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output ir_fields_t  fields,
    output logic [15:0] sximm8
);

    assign fields.opcode = ir[15:13];
    assign fields.op     = ir[12:11];
    assign fields.rn     = ir[10:8];
    assign fields.rd     = ir[7:5];
    assign fields.sh     = ir[4:3];
    assign fields.rm     = ir[2:0];
    assign sximm8        = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus the control FSM that sequences datapath
// register reads, ALU operation and write-back for one instruction.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    state_t     state, next_state;
    logic [15:0] ir;
    ir_fields_t f;
    logic [15:0] sximm8;

    logic is_mov_imm, is_mov_reg, is_cmp, needs_a, b_only;
    nsel_t nsel_r, nsel_w;
    logic write_raw, loada_raw, loadb_raw, loadc_raw, loads_raw;

    instruction_decoder u_dec (
        .ir     (ir),
        .fields (f),
        .sximm8 (sximm8)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= next_state;
            if (load && state == S_WAIT)
                ir <= in;
        end
    end

    assign is_mov_imm = (f.opcode == OPC_MOV) && (f.op == OP_MOV_IMM);
    assign is_mov_reg = (f.opcode == OPC_MOV) && (f.op == OP_MOV_REG);
    assign is_cmp     = (f.opcode == OPC_ALU) && (f.op == OP_CMP);
    assign needs_a    = (f.opcode == OPC_ALU) && (f.op != OP_MVN);
    assign b_only     = is_mov_reg || ((f.opcode == OPC_ALU) && (f.op == OP_MVN));

    always_comb begin
        next_state = state;
        w          = 1'b0;
        nsel_r     = NSEL_RN;
        nsel_w     = NSEL_RN;
        write_raw  = 1'b0;
        vsel       = 1'b0;
        loada_raw  = 1'b0;
        loadb_raw  = 1'b0;
        loadc_raw  = 1'b0;
        loads_raw  = 1'b0;
        asel       = 1'b0;
        shift      = 2'b00;
        ALUop      = ALU_ADD;
        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)
                    next_state = S_WRITE_IMM;
                else if (needs_a)
                    next_state = S_GET_A;
                else if (b_only)
                    next_state = S_GET_B;
                else
                    next_state = S_WAIT;
            end
            S_WRITE_IMM: begin
                write_raw  = 1'b1;
                vsel       = 1'b1;
                next_state = S_WAIT;
            end
            S_GET_A: begin
                loada_raw  = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                loadb_raw  = 1'b1;
                nsel_r     = NSEL_RM;
                next_state = S_ALU;
            end
            S_ALU: begin
                shift      = f.sh;
                // MOV reg is C = 0 + sh(Rm): zero the A operand and force add
                ALUop      = is_mov_reg ? ALU_ADD : f.op;
                asel       = is_mov_reg;
                loadc_raw  = !is_cmp;
                loads_raw  = is_cmp;
                next_state = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                write_raw  = 1'b1;
                nsel_w     = NSEL_RD;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase
    end

    // Strobes are masked while reset is high so an in-flight write never lands
    assign write       = write_raw & ~reset;
    assign loada       = loada_raw & ~reset;
    assign loadb       = loadb_raw & ~reset;
    assign loadc       = loadc_raw & ~reset;
    assign loads       = loads_raw & ~reset;
    assign bsel        = 1'b0;
    assign readnum     = select_reg(nsel_r, f);
    assign writenum    = select_reg(nsel_w, f);
    assign datapath_in = sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-instruction expected output
// traces and latencies derived from the ISA rules, directed plus random runs.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int n_cmp = 0;
    int n_bad = 0;

    typedef logic [34:0] ov_t;
    ov_t exp_q[$];

    cpu_controller dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
        .ALUop(ALUop), .datapath_in(datapath_in)
    );

    always #5 clk = ~clk;

    function automatic ov_t pk(input logic wv, input logic [2:0] rnum, input logic [2:0] wnum,
                               input logic wr, input logic vs, input logic la, input logic lb,
                               input logic lc, input logic ls, input logic as,
                               input logic [1:0] sh, input logic [1:0] aop, input logic [15:0] dp);
        return {wv, rnum, wnum, wr, vs, la, lb, lc, ls, as, 1'b0, sh, aop, dp};
    endfunction

    function automatic ov_t obs();
        return {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, ALUop, datapath_in};
    endfunction

    // Edges from the s-sampling edge until w is high again
    function automatic int latency_of(input logic [15:0] ir);
        logic [2:0] opc;
        logic [1:0] op;
        opc = ir[15:13];
        op  = ir[12:11];
        if (opc == 3'b110 && op == 2'b10) return 3;
        if (opc == 3'b110 && op == 2'b00) return 5;
        if (opc == 3'b101 && (op == 2'b01 || op == 2'b11)) return 5;
        if (opc == 3'b101) return 6;
        return 2;
    endfunction

    // Expected outputs after each edge following the s-sampling edge
    function automatic void build_trace(input logic [15:0] ir);
        logic [2:0] rn, rd, rm, opc;
        logic [1:0] sh, op;
        logic [15:0] dp;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5];
        sh = ir[4:3]; rm = ir[2:0];
        dp = {{8{ir[7]}}, ir[7:0]};
        exp_q.delete();
        exp_q.push_back(pk(0, rn, rn, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp));
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(pk(0, rn, rn, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp));
        end else if (opc == 3'b110 && op == 2'b00) begin
            exp_q.push_back(pk(0, rm, rn, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, dp));
            exp_q.push_back(pk(0, rn, rn, 0, 0, 0, 0, 1, 0, 1, sh, 2'b00, dp));
            exp_q.push_back(pk(0, rn, rd, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp));
        end else if (opc == 3'b101) begin
            if (op != 2'b11)
                exp_q.push_back(pk(0, rn, rn, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, dp));
            exp_q.push_back(pk(0, rm, rn, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, dp));
            exp_q.push_back(pk(0, rn, rn, 0, 0, 0, 0, op != 2'b01, op == 2'b01, 0, sh, op, dp));
            if (op != 2'b01)
                exp_q.push_back(pk(0, rn, rd, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp));
        end
        exp_q.push_back(pk(1, rn, rn, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp));
    endfunction

    // Walks the expected trace; assumes inputs for the s-sampling edge are already set
    task automatic walk_trace(input string name, input logic [15:0] ir, input bit busy_load,
                              input bit hold_s, input bit chain, input logic [15:0] next_ir);
        int first_w;
        ov_t got;
        first_w = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            got = obs();
            n_cmp++;
            if (got !== exp_q[k]) begin
                n_bad++;
                $display("FAIL %s ir=%h cycle=%0d got=%h want=%h", name, ir, k, got, exp_q[k]);
            end
            if (w === 1'b1 && first_w < 0) first_w = k + 1;
            s    = hold_s;
            load = busy_load && (k < exp_q.size() - 1);
            in   = busy_load ? 16'h1234 : ir;
            if (chain && k == exp_q.size() - 1) begin
                load = 1'b1;
                in   = next_ir;
            end
        end
        n_cmp++;
        if (first_w !== latency_of(ir)) begin
            n_bad++;
            $display("FAIL %s_latency ir=%h got=%0d want=%0d", name, ir, first_w, latency_of(ir));
        end
    endtask

    task automatic run_instr(input string name, input logic [15:0] ir,
                             input bit same_cycle, input bit busy_load);
        @(negedge clk);
        load = 1'b1;
        in   = ir;
        s    = same_cycle;
        if (!same_cycle) begin
            @(negedge clk);
            load = 1'b0;
            s    = 1'b1;
        end
        build_trace(ir);
        walk_trace(name, ir, busy_load, 1'b0, 1'b0, 16'h0000);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0000)) begin
            n_bad++;
            $display("FAIL reset_values got=%h", obs());
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [11:0] strobes;
        // reset in GET_B of ADD
        @(negedge clk);
        load = 1'b1; in = 16'hA148; s = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            load = 1'b0; s = 1'b0;
        end
        n_cmp++;
        if (loadb !== 1'b1 || readnum !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid_getb got loadb=%b readnum=%0d want 1/0", loadb, readnum);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        strobes = {w, write, vsel, loada, loadb, loadc, loads, asel, shift, ALUop};
        n_cmp++;
        if (strobes !== 12'b1000_0000_0000) begin
            n_bad++;
            $display("FAIL reset_mid_idle got=%b want=100000000000", strobes);
        end
        // reset while in WRITE_REG must mask the write
        @(negedge clk);
        load = 1'b1; in = 16'hA148; s = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            load = 1'b0; s = 1'b0;
        end
        n_cmp++;
        if (write !== 1'b1 || writenum !== 3'd2) begin
            n_bad++;
            $display("FAIL reset_wr_before got write=%b wnum=%0d want 1/2", write, writenum);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (write !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wr_suppress got write=%b want 0", write);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (w !== 1'b1 || write !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wr_after got w=%b write=%b want 1/0", w, write);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mov_imm();
        run_instr("mov_imm_pos", 16'hD007, 1'b0, 1'b0);
        run_instr("mov_imm_neg", 16'hD0FF, 1'b1, 1'b0);
    endtask

    task automatic test_alu();
        run_instr("add", 16'hA148, 1'b0, 1'b0);
        run_instr("cmp", 16'hA900, 1'b0, 1'b0);
        run_instr("mov_reg", 16'hC061, 1'b1, 1'b0);
        run_instr("mvn", 16'hB881, 1'b0, 1'b0);
    endtask

    task automatic test_unsupported();
        run_instr("unsup_zero", 16'h0000, 1'b0, 1'b0);
        run_instr("unsup_opc7", 16'hE123, 1'b1, 1'b0);
        run_instr("unsup_mov01", 16'hC8FF, 1'b0, 1'b0);
    endtask

    task automatic test_busy_load();
        run_instr("busy_add", 16'hA148, 1'b0, 1'b1);
        run_instr("busy_movi", 16'hD5A5, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        load = 1'b1; in = 16'hA148; s = 1'b1;
        build_trace(16'hA148);
        walk_trace("b2b_first", 16'hA148, 1'b0, 1'b1, 1'b1, 16'hD0F0);
        build_trace(16'hD0F0);
        walk_trace("b2b_second", 16'hD0F0, 1'b0, 1'b0, 1'b0, 16'h0000);
        load = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] ir;
        int kind;
        for (int i = 0; i < 40; i++) begin
            ir   = 16'($urandom);
            kind = $urandom_range(0, 6);
            case (kind)
                0: ir[15:11] = 5'b11010;
                1: ir[15:11] = 5'b11000;
                2: ir[15:11] = 5'b10100;
                3: ir[15:11] = 5'b10101;
                4: ir[15:11] = 5'b10110;
                5: ir[15:11] = 5'b10111;
                default: ;
            endcase
            run_instr("random", ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_alu();
        test_unsupported();
        test_busy_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
